mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
- Parametrised N-channel line-memory arbiter; successor to the fixed two-port I/D arbiter.
- Sits between NUM_CH cache pmem ports (I-cache, D-cache, future L2/prefetcher) and the single cacheline_adaptor line port.
- Round-robin fairness; one outstanding line transaction at a time.
- Each grant's address, data and operation are registered for the whole transaction.

Parameters:
NUM_CH, 2, number of requesting channels (1..8)
ADDR_W, 32, line address width
LINE_W, 256, cacheline width in bits

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
req_read  input  NUM_CH  per-channel line read request, held until resp
req_write  input  NUM_CH  per-channel line write request, held until resp
req_address  input  NUM_CH*ADDR_W  flattened; channel i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_CH*LINE_W  flattened; channel i at [i*LINE_W +: LINE_W]
req_rdata  output  LINE_W  read line, shared by all channels
req_resp  output  NUM_CH  one-hot completion pulse
mem_address  output  ADDR_W  to adaptor
mem_wdata  output  LINE_W  to adaptor
mem_read  output  1  to adaptor
mem_write  output  1  to adaptor
mem_rdata  input  LINE_W  from adaptor
mem_resp  input  1  from adaptor
grant_idx  output  $clog2(NUM_CH) (min 1)  channel currently owning memory
busy  output  1  high in any state except IDLE

Behaviour:
- Clock is clk. Reset is synchronous and active-low: reset_n sampled low at a rising edge.
- On reset:
  - state=IDLE; rr_ptr=0; grant_idx=0.
  - mem_read, mem_write, req_resp and busy are all 0.
  - mem_address and mem_wdata are 0.
- Channel i is pending when req_read[i] or req_write[i] is set.
- If a channel drives both read and write, write wins and the read is ignored.
- States:
  - IDLE:
    - If any channel is pending, pick the first pending channel at or after rr_ptr, wrapping modulo NUM_CH.
    - Register the winner's index, address, wdata and op (read/write). Go to ISSUE.
    - If nothing is pending, stay in IDLE.
  - ISSUE:
    - Drive mem_read or mem_write from the registered op; address and wdata come from the registers.
    - Hold until mem_resp=1.
    - In the mem_resp cycle: req_resp[grant_idx]=1 combinationally and req_rdata=mem_rdata. mem_read/mem_write stay high in that cycle. Go to SETTLE.
  - SETTLE:
    - One cycle with all outputs idle so the requester can drop its request.
    - rr_ptr = (grant_idx+1) mod NUM_CH. Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> mem_read/mem_write high at cycle 1.
  - mem_resp at cycle k -> req_resp at cycle k.
  - Next grant is possible at cycle k+2 (IDLE), with issue at k+3.
- req_rdata is the mem_rdata passthrough. It is valid only while req_resp is high; undefined otherwise.
- req_resp is never high for more than one cycle and never high for more than one channel.
- Request changes after registration (ISSUE/SETTLE) are ignored until the next IDLE.
- mem_resp received outside ISSUE is ignored.
- A channel that drops its request before it is granted loses nothing and no transaction is generated.
- Reset mid-transaction aborts it: outputs return to reset values the next cycle. The adaptor is reset in the same cycle.
- NUM_CH=1: rr_ptr and grant_idx are constant 0; behaviour is otherwise identical.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index pending channel always wins (channel 0 highest); rr_ptr is removed.
- Undefined: round-robin as specified above.
- Handshake, latency and SETTLE timing are identical in both modes.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, SETTLE}.
  - arb_op_t enum {OP_READ, OP_WRITE}.
  - Default constants ARB_ADDR_W=32 and ARB_LINE_W=256.
- Sub-module rr_pick: combinational; inputs pending[NUM_CH] and rr_ptr; outputs valid and idx.
  - Implemented as a double-width masked priority encode.
  - Fixed-priority mode ties rr_ptr to 0.

Test Plan:
- Single read: ch0 read addr 0x0000_1000; mem_resp after 4 cycles with rdata=256'hA5..A5.
  - mem_read is high cycles 1-4.
  - req_resp=2'b01 in cycle 4 carrying 0xA5..A5.
  - busy drops in cycle 6.
- Simultaneous: ch0 read 0x100 and ch1 write 0x200 at reset exit.
  - ch0 is served first, then ch1 (mem_write, wdata matches ch1).
  - With ARB_FIXED_PRIO_EN the order is the same.
- Fairness, NUM_CH=4: all channels request continuously.
  - Grants go 0,1,2,3,0.
  - With ARB_FIXED_PRIO_EN, ch0 is always granted.
- Read+write on ch2 together: a write is issued to ch2's address; no read occurs.
- Reset mid-ISSUE: reset_n=0 during cycle 2 of a read.
  - Next cycle: mem_read=0, busy=0, rr_ptr=0.
  - A re-issued request is served from IDLE normally.
- Spurious mem_resp in IDLE: no req_resp pulses and the state is unchanged.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and defaults for the N-channel line-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, SETTLE)
//   arb_op_t    : registered operation of the current grant
//   ARB_ADDR_W / ARB_LINE_W : default address and cacheline widths
//   arb_idx_w() : channel-index width, never below 1 bit
// No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr_if
// Bundles the requester-side and adaptor-side buses of mem_arbiter_rr.
//   req_read/req_write [NUM_CH]   per-channel line requests (held until resp)
//   req_address [NUM_CH*ADDR_W]   flattened, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata   [NUM_CH*LINE_W]   flattened, channel i at [i*LINE_W +: LINE_W]
//   req_rdata   [LINE_W]          read line shared by all channels
//   req_resp    [NUM_CH]          one-hot completion pulse
//   mem_*                         single line port to the cacheline adaptor
//   grant_idx, busy               arbitration status
// Modports: slave = arbiter view, master = environment view.
// -----------------------------------------------------------------------------
interface mem_arbiter_rr_if
    import arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) ();

    localparam int IDX_W = arb_idx_w(NUM_CH);

    logic [NUM_CH-1:0]        req_read;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH*ADDR_W-1:0] req_address;
    logic [NUM_CH*LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0]        req_rdata;
    logic [NUM_CH-1:0]        req_resp;

    logic [ADDR_W-1:0]        mem_address;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [LINE_W-1:0]        mem_rdata;
    logic                     mem_resp;

    logic [IDX_W-1:0]         grant_idx;
    logic                     busy;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        output req_rdata, req_resp, mem_address, mem_wdata, mem_read, mem_write,
               grant_idx, busy
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        input  req_rdata, req_resp, mem_address, mem_wdata, mem_read, mem_write,
               grant_idx, busy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner selection: first pending channel at or after rr_ptr_i,
// wrapping modulo NUM_CH.
//   pending_i [NUM_CH]  channels with an active request
//   rr_ptr_i  [IDX_W]   search start (tie to 0 for fixed priority)
//   valid_o             any channel pending
//   idx_o     [IDX_W]   winning channel
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] pending_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] masked;

    always_comb begin
        dbl    = {pending_i, pending_i};
        // Masking off positions below rr_ptr in the doubled vector leaves the
        // upper copy intact, so the wrap-around candidates are found above.
        masked = dbl & ({(2*NUM_CH){1'b1}} << rr_ptr_i);
        valid_o = |pending_i;
        idx_o   = '0;
        // Scan downward so the lowest set position wins.
        for (int j = 2*NUM_CH-1; j >= 0; j--) begin
            if (masked[j]) begin
                idx_o = IDX_W'(j % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// N-channel line-memory arbiter between cache pmem ports and one cacheline
// adaptor. One outstanding transaction; the winner's address, data and op are
// registered for the whole transaction.
//   clk      : clock
//   reset_n  : synchronous active-low reset
//   arb_if   : mem_arbiter_rr_if.slave (requester and adaptor buses, status)
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest,
// no rotating pointer); default is round-robin.
// -----------------------------------------------------------------------------
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_arbiter_rr_if.slave  arb_if
);

    localparam int IDX_W = arb_idx_w(NUM_CH);

    arb_state_t        state_q;
    arb_op_t           op_q;
    logic [IDX_W-1:0]  grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic [NUM_CH-1:0] pending;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  pick_ptr;
    logic              resp_hit;
    logic [NUM_CH-1:0] resp_onehot;

    assign pending = arb_if.req_read | arb_if.req_write;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    assign rr_ptr_d = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    assign pick_ptr = rr_ptr_q;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .pending_i (pending),
        .rr_ptr_i  (pick_ptr),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    // Completion is combinational so the requester sees it in the mem_resp cycle.
    assign resp_hit = (state_q == ISSUE) && arb_if.mem_resp;

    always_comb begin
        resp_onehot           = '0;
        resp_onehot[grant_q]  = resp_hit;
    end

    assign arb_if.req_resp    = resp_onehot;
    assign arb_if.req_rdata   = arb_if.mem_rdata;
    assign arb_if.mem_address = addr_q;
    assign arb_if.mem_wdata   = wdata_q;
    assign arb_if.mem_read    = (state_q == ISSUE) && (op_q == OP_READ);
    assign arb_if.mem_write   = (state_q == ISSUE) && (op_q == OP_WRITE);
    assign arb_if.grant_idx   = grant_q;
    assign arb_if.busy        = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        addr_q  <= arb_if.req_address[int'(pick_idx)*ADDR_W +: ADDR_W];
                        wdata_q <= arb_if.req_wdata[int'(pick_idx)*LINE_W +: LINE_W];
                        // A channel asserting both read and write is a write.
                        op_q    <= arb_if.req_write[pick_idx] ? OP_WRITE : OP_READ;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (arb_if.mem_resp) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_q <= rr_ptr_d;
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
